// File: rtl/gomoku_pkg.sv
// Shared board constants: geometry, colour encoding and display cell codes.
package gomoku_pkg;
    localparam int BOARD_SIZE  = 15;
    localparam int BOARD_CELLS = BOARD_SIZE * BOARD_SIZE;
    localparam int WIN_HALF    = 4;
    localparam int WIN_W       = 2 * WIN_HALF + 1;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
endpackage

// File: rtl/board_line_window.sv
// One direction's 9-cell line window around (cy, cx) for both colours.
// Latency 1 cycle (registered); no backpressure, off-board cells read 0.
module board_line_window
    import gomoku_pkg::*;
#(
    parameter int DY       = 0,
    parameter int DX       = 1,
    parameter int HALF_WIN = WIN_HALF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BOARD_CELLS-1:0]   black_map,
    input  logic [BOARD_CELLS-1:0]   white_map,
    input  logic [3:0]               cy,
    input  logic [3:0]               cx,
    output logic [2*HALF_WIN:0]      black_win,
    output logic [2*HALF_WIN:0]      white_win
);
    localparam int W = 2 * HALF_WIN + 1;

    logic         centre_ok;
    logic [W-1:0] black_nxt;
    logic [W-1:0] white_nxt;

    assign centre_ok = (cy < 4'(BOARD_SIZE)) && (cx < 4'(BOARD_SIZE));

    for (genvar i = 0; i < W; i++) begin : g_cell
        localparam int D = i - HALF_WIN;
        logic signed [6:0] r;
        logic signed [6:0] c;
        logic              on_board;
        logic [7:0]        idx;

        assign r        = $signed({3'b000, cy}) + 7'(DY * D);
        assign c        = $signed({3'b000, cx}) + 7'(DX * D);
        assign on_board = (r >= 0) && (r < 7'(BOARD_SIZE)) && (c >= 0) && (c < 7'(BOARD_SIZE));
        assign idx      = on_board ? 8'(r[3:0]) * 8'(BOARD_SIZE) + 8'(c[3:0]) : 8'd0;
        assign black_nxt[i] = centre_ok && on_board && black_map[idx];
        assign white_nxt[i] = centre_ok && on_board && white_map[idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            black_win <= '0;
            white_win <= '0;
        end else begin
            black_win <= black_nxt;
            white_win <= white_nxt;
        end
    end
endmodule

// File: rtl/gomoku_board.sv
// 15x15 gomoku board store: synchronised clear/place commands, line windows, counters.
// Command latency SYNC_STAGES+1 edges; windows 1 cycle; no backpressure (illegal writes flag write_err).
module gomoku_board #(
    parameter int BOARD_SIZE  = 15,
    parameter int SYNC_STAGES = 2,
    parameter int HALF_WIN    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_clr,
    input  logic                 data_write,
    input  logic [3:0]           cursor_y,
    input  logic [3:0]           cursor_x,
    input  logic                 crt_player,
    input  logic [3:0]           consider_y,
    input  logic [3:0]           consider_x,
    input  logic [3:0]           disp_y,
    input  logic [3:0]           disp_x,
    output logic [2*HALF_WIN:0]  black_y,
    output logic [2*HALF_WIN:0]  black_x,
    output logic [2*HALF_WIN:0]  black_yx,
    output logic [2*HALF_WIN:0]  black_xy,
    output logic [2*HALF_WIN:0]  white_y,
    output logic [2*HALF_WIN:0]  white_x,
    output logic [2*HALF_WIN:0]  white_yx,
    output logic [2*HALF_WIN:0]  white_xy,
    output logic [14:0]          chess_row,
    output logic [1:0]           disp_cell,
    output logic [7:0]           black_count,
    output logic [7:0]           white_count,
    output logic                 board_full,
    output logic                 write_err
);
    import gomoku_pkg::*;

    localparam int CELLS = BOARD_SIZE * BOARD_SIZE;

    logic [CELLS-1:0]       black_map;
    logic [CELLS-1:0]       white_map;
    logic [CELLS-1:0]       occ;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic                   clr_dly;
    logic                   wr_dly;
    logic                   clr_pls;
    logic                   wr_pls;
    logic                   wr_on;
    logic                   wr_ok;
    logic [7:0]             wr_idx;
    logic                   disp_on;
    logic [7:0]             disp_idx;
    logic [7:0]             row_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_sync <= '0;
            wr_sync  <= '0;
            clr_dly  <= 1'b0;
            wr_dly   <= 1'b0;
        end else begin
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], data_clr};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], data_write};
            clr_dly  <= clr_sync[SYNC_STAGES-1];
            wr_dly   <= wr_sync[SYNC_STAGES-1];
        end
    end

    assign clr_pls = clr_sync[SYNC_STAGES-1] && !clr_dly;
    assign wr_pls  = wr_sync[SYNC_STAGES-1] && !wr_dly;

    assign occ    = black_map | white_map;
    assign wr_on  = (cursor_y < 4'(BOARD_SIZE)) && (cursor_x < 4'(BOARD_SIZE));
    assign wr_idx = wr_on ? 8'(cursor_y) * 8'(BOARD_SIZE) + 8'(cursor_x) : 8'd0;
    assign wr_ok  = wr_on && !occ[wr_idx];

    // Clear wins over a coincident write; the write is simply lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            black_map   <= '0;
            white_map   <= '0;
            black_count <= 8'd0;
            white_count <= 8'd0;
            write_err   <= 1'b0;
        end else if (clr_pls) begin
            black_map   <= '0;
            white_map   <= '0;
            black_count <= 8'd0;
            white_count <= 8'd0;
            write_err   <= 1'b0;
        end else if (wr_pls) begin
            if (!wr_ok) begin
                write_err <= 1'b1;
            end else if (crt_player == WHITE) begin
                white_map[wr_idx] <= 1'b1;
                if (white_count != 8'(CELLS)) white_count <= white_count + 8'd1;
            end else begin
                black_map[wr_idx] <= 1'b1;
                if (black_count != 8'(CELLS)) black_count <= black_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) board_full <= 1'b0;
        else      board_full <= ({1'b0, black_count} + {1'b0, white_count}) == 9'(CELLS);
    end

    // Off-board rows report fully occupied so the FSM never tries to place there.
    assign row_base = (cursor_y < 4'(BOARD_SIZE)) ? 8'(cursor_y) * 8'(BOARD_SIZE) : 8'd0;
    always_comb begin
        chess_row = '1;
        if (cursor_y < 4'(BOARD_SIZE)) begin
            for (int j = 0; j < BOARD_SIZE; j++) chess_row[j] = occ[row_base + 8'(j)];
        end
    end

    assign disp_on  = (disp_y < 4'(BOARD_SIZE)) && (disp_x < 4'(BOARD_SIZE));
    assign disp_idx = disp_on ? 8'(disp_y) * 8'(BOARD_SIZE) + 8'(disp_x) : 8'd0;
    always_comb begin
        disp_cell = CELL_EMPTY;
        if (disp_on && black_map[disp_idx])      disp_cell = CELL_BLACK;
        else if (disp_on && white_map[disp_idx]) disp_cell = CELL_WHITE;
    end

    board_line_window #(.DY(1), .DX(0), .HALF_WIN(HALF_WIN)) u_win_y (
        .clk(clk), .rst(rst), .black_map(black_map), .white_map(white_map),
        .cy(consider_y), .cx(consider_x), .black_win(black_y), .white_win(white_y));
    board_line_window #(.DY(0), .DX(1), .HALF_WIN(HALF_WIN)) u_win_x (
        .clk(clk), .rst(rst), .black_map(black_map), .white_map(white_map),
        .cy(consider_y), .cx(consider_x), .black_win(black_x), .white_win(white_x));
    board_line_window #(.DY(1), .DX(1), .HALF_WIN(HALF_WIN)) u_win_yx (
        .clk(clk), .rst(rst), .black_map(black_map), .white_map(white_map),
        .cy(consider_y), .cx(consider_x), .black_win(black_yx), .white_win(white_yx));
    board_line_window #(.DY(1), .DX(-1), .HALF_WIN(HALF_WIN)) u_win_xy (
        .clk(clk), .rst(rst), .black_map(black_map), .white_map(white_map),
        .cy(consider_y), .cx(consider_x), .black_win(black_xy), .white_win(white_xy));
endmodule

// File: tb/tb_gomoku_board.sv
// Directed bench for gomoku_board: placement, windows, clear priority, fill and async reset.
module tb_gomoku_board;
    logic       clk = 1'b0;
    logic       rst;
    logic       data_clr, data_write, crt_player;
    logic [3:0] cursor_y, cursor_x, consider_y, consider_x, disp_y, disp_x;
    logic [8:0] black_y, black_x, black_yx, black_xy;
    logic [8:0] white_y, white_x, white_yx, white_xy;
    logic [14:0] chess_row;
    logic [1:0] disp_cell;
    logic [7:0] black_count, white_count;
    logic       board_full, write_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gomoku_board dut (
        .clk(clk), .rst(rst), .data_clr(data_clr), .data_write(data_write),
        .cursor_y(cursor_y), .cursor_x(cursor_x), .crt_player(crt_player),
        .consider_y(consider_y), .consider_x(consider_x), .disp_y(disp_y), .disp_x(disp_x),
        .black_y(black_y), .black_x(black_x), .black_yx(black_yx), .black_xy(black_xy),
        .white_y(white_y), .white_x(white_x), .white_yx(white_yx), .white_xy(white_xy),
        .chess_row(chess_row), .disp_cell(disp_cell), .black_count(black_count),
        .white_count(white_count), .board_full(board_full), .write_err(write_err));

    // Raise data_write for 3 edges (pulse lands on the 3rd), then idle so the edge detector re-arms.
    task automatic put_stone(input logic [3:0] y, input logic [3:0] x, input logic p);
        @(negedge clk);
        cursor_y = y; cursor_x = x; crt_player = p; data_write = 1'b1;
        repeat (3) @(negedge clk);
        data_write = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        data_clr = 1'b1;
        repeat (3) @(negedge clk);
        data_clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; data_clr = 1'b0; data_write = 1'b0; crt_player = 1'b0;
        cursor_y = 4'd7; cursor_x = 4'd0; consider_y = 4'd7; consider_x = 4'd7;
        disp_y = 4'd7; disp_x = 4'd7;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({black_y, black_x, black_yx, black_xy, white_y, white_x, white_yx, white_xy} !== 72'd0) begin n_bad++; $display("FAIL reset_windows got %h want 0", {black_y, black_x, black_yx, black_xy, white_y, white_x, white_yx, white_xy}); end
        n_cmp++; if ({black_count, white_count} !== 16'd0) begin n_bad++; $display("FAIL reset_counts got %h want 0000", {black_count, white_count}); end
        n_cmp++; if (chess_row !== 15'h0000) begin n_bad++; $display("FAIL reset_chess_row got %h want 0000", chess_row); end
        n_cmp++; if ({board_full, write_err, disp_cell} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {board_full, write_err, disp_cell}); end
    endtask

    task automatic test_place();
        // Black at (7,7) driven by hand to pin the pulse to the 3rd clock edge.
        @(negedge clk);
        cursor_y = 4'd7; cursor_x = 4'd7; crt_player = 1'b0; data_write = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (black_count !== 8'd0) begin n_bad++; $display("FAIL place_latency_early got %0d want 0", black_count); end
        @(negedge clk);
        n_cmp++; if (black_count !== 8'd1) begin n_bad++; $display("FAIL place_latency_edge3 got %0d want 1", black_count); end
        data_write = 1'b0;
        repeat (3) @(negedge clk);
        put_stone(4'd7, 4'd8, 1'b1);
        cursor_y = 4'd7;
        #1;
        n_cmp++; if ({black_count, white_count} !== {8'd1, 8'd1}) begin n_bad++; $display("FAIL place_counts got %h want 0101", {black_count, white_count}); end
        n_cmp++; if (black_x !== 9'b000010000) begin n_bad++; $display("FAIL place_black_x got %b want 000010000", black_x); end
        n_cmp++; if (white_x !== 9'b000100000) begin n_bad++; $display("FAIL place_white_x got %b want 000100000", white_x); end
        n_cmp++; if ({black_y, white_y, white_yx} !== {9'b000010000, 9'd0, 9'd0}) begin n_bad++; $display("FAIL place_y_yx got %h want %h", {black_y, white_y, white_yx}, {9'b000010000, 9'd0, 9'd0}); end
        n_cmp++; if (chess_row !== 15'h0180) begin n_bad++; $display("FAIL place_chess_row got %h want 0180", chess_row); end
        disp_y = 4'd7; disp_x = 4'd8; #1;
        n_cmp++; if (disp_cell !== 2'b10) begin n_bad++; $display("FAIL place_disp_white got %b want 10", disp_cell); end
        disp_y = 4'd15; disp_x = 4'd0; #1;
        n_cmp++; if (disp_cell !== 2'b00) begin n_bad++; $display("FAIL place_disp_off got %b want 00", disp_cell); end
        cursor_y = 4'd15; #1;
        n_cmp++; if (chess_row !== 15'h7FFF) begin n_bad++; $display("FAIL place_chess_row_off got %h want 7fff", chess_row); end
    endtask

    task automatic test_occupied_and_clear();
        put_stone(4'd7, 4'd7, 1'b1);
        n_cmp++; if ({white_count, write_err} !== {8'd1, 1'b1}) begin n_bad++; $display("FAIL occ_white_err got %h want 03", {white_count, write_err}); end
        n_cmp++; if ({black_x, white_x} !== {9'b000010000, 9'b000100000}) begin n_bad++; $display("FAIL occ_maps_kept got %h want %h", {black_x, white_x}, {9'b000010000, 9'b000100000}); end
        pulse_clear();
        n_cmp++; if ({black_count, white_count, write_err} !== 17'd0) begin n_bad++; $display("FAIL clear_state got %h want 0", {black_count, white_count, write_err}); end
        n_cmp++; if ({black_y, black_x, black_yx, black_xy, white_y, white_x, white_yx, white_xy} !== 72'd0) begin n_bad++; $display("FAIL clear_windows got %h want 0", {black_y, black_x, black_yx, black_xy, white_y, white_x, white_yx, white_xy}); end
        put_stone(4'd3, 4'd15, 1'b0);
        n_cmp++; if ({black_count, write_err} !== {8'd0, 1'b1}) begin n_bad++; $display("FAIL offboard_write got %h want 001", {black_count, write_err}); end
        pulse_clear();
    endtask

    task automatic test_edges();
        put_stone(4'd0, 4'd0, 1'b0);
        put_stone(4'd14, 4'd14, 1'b1);
        put_stone(4'd0, 4'd14, 1'b1);
        consider_y = 4'd0; consider_x = 4'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (black_yx !== 9'b000010000) begin n_bad++; $display("FAIL edge_yx00 got %b want 000010000", black_yx); end
        n_cmp++; if (black_xy !== 9'b000010000) begin n_bad++; $display("FAIL edge_xy00 got %b want 000010000", black_xy); end
        consider_y = 4'd2; consider_x = 4'd2;
        repeat (2) @(negedge clk);
        n_cmp++; if ({black_yx, black_xy} !== {9'b000000100, 9'd0}) begin n_bad++; $display("FAIL edge_yx22 got %h want %h", {black_yx, black_xy}, {9'b000000100, 9'd0}); end
        consider_y = 4'd14; consider_x = 4'd14;
        repeat (2) @(negedge clk);
        n_cmp++; if ({white_yx, white_x} !== {9'b000010000, 9'b000010000}) begin n_bad++; $display("FAIL edge_corner got %h want %h", {white_yx, white_x}, {9'b000010000, 9'b000010000}); end
        consider_y = 4'd15; consider_x = 4'd15;
        repeat (2) @(negedge clk);
        n_cmp++; if ({white_y, white_x, white_yx, white_xy} !== 36'd0) begin n_bad++; $display("FAIL edge_consider_off got %h want 0", {white_y, white_x, white_yx, white_xy}); end
        consider_y = 4'd2; consider_x = 4'd12;
        repeat (2) @(negedge clk);
        n_cmp++; if ({white_xy, white_yx} !== {9'b000000100, 9'd0}) begin n_bad++; $display("FAIL edge_anti_diag got %h want %h", {white_xy, white_yx}, {9'b000000100, 9'd0}); end
        pulse_clear();
    endtask

    task automatic test_hold_and_collide();
        @(negedge clk);
        cursor_y = 4'd5; cursor_x = 4'd5; crt_player = 1'b0; data_write = 1'b1;
        repeat (50) @(negedge clk);
        data_write = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({black_count, white_count} !== {8'd1, 8'd0}) begin n_bad++; $display("FAIL hold_one_stone got %h want 0100", {black_count, white_count}); end
        cursor_y = 4'd6; cursor_x = 4'd6; crt_player = 1'b1;
        data_clr = 1'b1; data_write = 1'b1;
        repeat (10) @(negedge clk);
        data_clr = 1'b0; data_write = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({black_count, white_count, write_err} !== 17'd0) begin n_bad++; $display("FAIL collide_counts got %h want 0", {black_count, white_count, write_err}); end
        disp_y = 4'd6; disp_x = 4'd6; #1;
        n_cmp++; if (disp_cell !== 2'b00) begin n_bad++; $display("FAIL collide_cell66 got %b want 00", disp_cell); end
        disp_y = 4'd5; disp_x = 4'd5; #1;
        n_cmp++; if (disp_cell !== 2'b00) begin n_bad++; $display("FAIL collide_cell55 got %b want 00", disp_cell); end
    endtask

    task automatic test_fill_and_reset();
        consider_y = 4'd7; consider_x = 4'd7;
        for (int k = 0; k < 224; k++) put_stone(4'(k / 15), 4'(k % 15), 1'(k % 2));
        n_cmp++; if (board_full !== 1'b0) begin n_bad++; $display("FAIL fill_not_full_224 got %b want 0", board_full); end
        put_stone(4'd14, 4'd14, 1'b0);
        n_cmp++; if ({board_full, black_count, white_count} !== {1'b1, 8'd113, 8'd112}) begin n_bad++; $display("FAIL fill_full got %h want %h", {board_full, black_count, white_count}, {1'b1, 8'd113, 8'd112}); end
        n_cmp++; if ({black_x, white_x, black_y} !== {9'b101010101, 9'b010101010, 9'b101010101}) begin n_bad++; $display("FAIL fill_windows got %h want %h", {black_x, white_x, black_y}, {9'b101010101, 9'b010101010, 9'b101010101}); end
        cursor_y = 4'd3; #1;
        n_cmp++; if (chess_row !== 15'h7FFF) begin n_bad++; $display("FAIL fill_chess_row got %h want 7fff", chess_row); end
        put_stone(4'd0, 4'd0, 1'b1);
        n_cmp++; if ({write_err, black_count, white_count} !== {1'b1, 8'd113, 8'd112}) begin n_bad++; $display("FAIL fill_extra_write got %h want %h", {write_err, black_count, white_count}, {1'b1, 8'd113, 8'd112}); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({black_count, white_count, board_full, write_err} !== 18'd0) begin n_bad++; $display("FAIL async_reset_state got %h want 0", {black_count, white_count, board_full, write_err}); end
        n_cmp++; if ({black_y, black_x, black_yx, black_xy, white_y, white_x, white_yx, white_xy} !== 72'd0) begin n_bad++; $display("FAIL async_reset_windows got %h want 0", {black_y, black_x, black_yx, black_xy, white_y, white_x, white_yx, white_xy}); end
        n_cmp++; if (chess_row !== 15'h0000) begin n_bad++; $display("FAIL async_reset_row got %h want 0000", chess_row); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_place();
        test_occupied_and_clear();
        test_edges();
        test_hold_and_collide();
        test_fill_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
